// File: rtl/signal_delayer.sv
// Programmable single-bit delay line: sig_in delayed by 0..2**DELAY_W-1 clock cycles.
// A free-running shift register feeds a tap multiplexer selected by delay_value.
module signal_delayer #(
  parameter int DELAY_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sig_in,
  input  logic [DELAY_W-1:0] delay_value,
  output logic               sig_out
);

  localparam int MAX_DELAY = 2**DELAY_W - 1;

  logic [MAX_DELAY:1] sr_q;
  logic [MAX_DELAY:1] sr_d;
  logic [MAX_DELAY:0] taps;

  always_comb begin
    sr_d    = '0;
    sr_d[1] = sig_in;
    for (int k = 2; k <= MAX_DELAY; k++) begin
      sr_d[k] = sr_q[k-1];
    end
  end

  // rstn is active-high despite its name; history is discarded immediately.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Tap 0 is the live input, giving a zero-latency path when delay_value is 0.
  assign taps = {sr_q, sig_in};

  always_comb begin
    sig_out = 1'b0;
    if (!rstn) begin
      sig_out = taps[delay_value];
    end
  end

endmodule

// File: tb/tb_signal_delayer.sv
// Directed self-checking bench for signal_delayer with hand-computed expected outputs.
module tb_signal_delayer;

  logic       clk;
  logic       rstn;
  logic       sig_in;
  logic [3:0] delay_value;
  logic       sig_out;

  int checkCount;
  int errorCount;

  signal_delayer #(.DELAY_W(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .sig_in      (sig_in),
    .delay_value (delay_value),
    .sig_out     (sig_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0b expected %0b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance to just after the next rising edge so outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic in_val, input logic [3:0] dly);
    sig_in      = in_val;
    delay_value = dly;
  endtask

  task automatic doReset();
    rstn = 1'b1;
    repeat (2) tick();
    rstn = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rstn       = 1'b1;
    applyStimulus(1'b0, 4'd5);

    // Reset hold with toggling input
    for (int i = 0; i < 20; i++) begin
      sig_in = ~sig_in;
      tick();
      checkOutput("reset_hold", sig_out, 1'b0);
    end
    applyStimulus(1'b1, 4'd0);
    #1;
    checkOutput("reset_hold_d0", sig_out, 1'b0);

    // Release with delay 5 and input held high
    applyStimulus(1'b1, 4'd5);
    rstn = 1'b0;
    #1;
    checkOutput("release_pre", sig_out, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      checkOutput($sformatf("release_d5_e%0d", i), sig_out, (i >= 5) ? 1'b1 : 1'b0);
    end

    // Unit delay
    applyStimulus(1'b0, 4'd1);
    doReset();
    sig_in = 1'b1;
    #1;
    checkOutput("unit_pre", sig_out, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      checkOutput($sformatf("unit_hi_e%0d", i), sig_out, 1'b1);
    end
    sig_in = 1'b0;
    #1;
    checkOutput("unit_fall_pre", sig_out, 1'b1);
    tick();
    checkOutput("unit_fall", sig_out, 1'b0);

    // Pass-through: toggle between edges, no clock involvement
    applyStimulus(1'b0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      sig_in = 1'b1;
      #1;
      checkOutput("pass_hi", sig_out, 1'b1);
      sig_in = 1'b0;
      #1;
      checkOutput("pass_lo", sig_out, 1'b0);
    end

    // Maximum delay: single-cycle pulse emerges exactly 15 edges later
    applyStimulus(1'b0, 4'd15);
    doReset();
    sig_in = 1'b1;
    tick();
    sig_in = 1'b0;
    checkOutput("max_e1", sig_out, 1'b0);
    for (int k = 2; k <= 20; k++) begin
      tick();
      checkOutput($sformatf("max_e%0d", k), sig_out, (k == 15) ? 1'b1 : 1'b0);
    end

    // Run-time change from delay 7 to delay 6
    applyStimulus(1'b0, 4'd7);
    doReset();
    sig_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checkOutput($sformatf("chg_d7_e%0d", i), sig_out, (i >= 7) ? 1'b1 : 1'b0);
    end
    applyStimulus(1'b0, 4'd6);
    #1;
    checkOutput("chg_switch", sig_out, 1'b1);
    for (int j = 1; j <= 10; j++) begin
      tick();
      checkOutput($sformatf("chg_d6_e%0d", j), sig_out, (j < 6) ? 1'b1 : 1'b0);
    end

    // Tap history retained: falling edge already in the register, select older tap
    applyStimulus(1'b1, 4'd3);
    repeat (2) tick();
    checkOutput("hist_d3", sig_out, 1'b0);
    delay_value = 4'd1;
    #1;
    checkOutput("hist_d1", sig_out, 1'b1);

    // Mid-run reset at delay 6
    applyStimulus(1'b1, 4'd6);
    repeat (20) tick();
    checkOutput("mid_before", sig_out, 1'b1);
    #2;
    rstn = 1'b1;
    #1;
    checkOutput("mid_async", sig_out, 1'b0);
    repeat (2) begin
      tick();
      checkOutput("mid_hold", sig_out, 1'b0);
    end
    rstn = 1'b0;
    #1;
    checkOutput("mid_release_pre", sig_out, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      checkOutput($sformatf("mid_e%0d", i), sig_out, (i >= 6) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/signal_delayer.md
Name: signal_delayer

Overview:
Programmable single-bit delay line. Outputs sig_in delayed by a run-time selectable number of clock cycles, from 0 to 15. Used to align control/strobe signals against pipelined datapaths. Implemented as a tapped shift register followed by an output tap multiplexer.

Parameters:
DELAY_W, 4, width of delay_value; sets the maximum delay.
MAX_DELAY, 2**DELAY_W-1 (15), number of shift-register stages; derived, not overridden independently.

Ports:
clk  input  1  rising-edge clock.
rstn  input  1  asynchronous reset, active-high (asserted = 1) despite the name.
sig_in  input  1  signal to be delayed; sampled on rising clk.
delay_value  input  DELAY_W  delay in clock cycles, 0..MAX_DELAY; may change at any time.
sig_out  output  1  delayed copy of sig_in.

Behaviour:
- State: shift register sr[1..MAX_DELAY], MAX_DELAY bits.
- Each rising clk edge with reset deasserted: sr[1] <= sig_in; sr[k] <= sr[k-1] for k = 2..MAX_DELAY.
- Reset (rstn = 1): asynchronously clears all sr bits to 0. sig_out = 0 while reset is asserted, for every delay_value, including 0.
- Output selection is combinational from the current delay_value:
  - delay_value = 0: sig_out = sig_in (combinational pass-through, zero latency).
  - delay_value = N, 1..MAX_DELAY: sig_out = sr[N], i.e. the value of sig_in sampled N rising edges earlier.
- Latency: an edge on sig_in appears on sig_out after exactly N rising clk edges, N = delay_value.
- delay_value change mid-stream:
  - The output switches to the new tap immediately in the same cycle.
  - Shift-register history is retained; no flush.
  - Glitches or dropped/duplicated pulses at the switch are permitted and are not required to be suppressed.
- After reset release:
  - Taps not yet filled read 0.
  - For the first N cycles, sig_out = 0 (when N > 0).
- Reset asserted mid-operation: all history is lost immediately (asynchronously). After release, behaviour is identical to a fresh start.
- The shift register always runs, independent of delay_value; history for larger delays is always available.
- Width rule: delay_value is unsigned. All values 0..2**DELAY_W-1 are legal, so there is no out-of-range case.

Test Plan:
- Reset hold: rstn = 1 for 20 cycles, sig_in toggling, delay_value = 5 -> sig_out = 0 throughout; rstn = 0 then sig_in = 1 held -> sig_out remains 0 for 5 edges, then 1 after the 5th rising edge.
- Unit delay: rstn = 0, delay_value = 1, sig_in = 1 for 10 cycles then 0 -> sig_out rises 1 edge after sig_in rises and falls 1 edge after sig_in falls.
- Pass-through: delay_value = 0, sig_in toggled between clock edges -> sig_out equals sig_in immediately, with no clock dependence.
- Maximum delay: delay_value = 15, single-cycle pulse on sig_in -> single-cycle pulse on sig_out exactly 15 edges later; no other pulses.
- Run-time change: sig_in = 1 for 10 cycles at delay 7, then sig_in = 0 for 10 cycles at delay 6 -> sig_out follows sr[7] then switches immediately to sr[6]; falling edge appears 6 edges after sig_in falls.
- Mid-run reset: delay_value = 6, sig_in = 1 for 20 cycles, assert rstn = 1 for 2 cycles -> sig_out drops to 0 asynchronously; after release with sig_in = 1, sig_out = 1 only after 6 edges.
